regfile_scoreboard: RTL and testbench

- Parametrised register file for the single-issue core: NR_READ combinational read ports, one write-back port, optional hardwired zero register, optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard. Decode allocates a destination register, and write-back clears it.
- Sits between decode/issue and write-back. Decode uses rd_busy and alloc_ready to generate stalls.

---
 rtl/regfile_scoreboard_pkg.sv | 24 ++
 rtl/regfile_scoreboard_read_port.sv | 42 ++++
 rtl/regfile_scoreboard.sv | 120 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helpers for the register file with busy scoreboard.
package regfile_scoreboard_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  // Widest busy vector the popcount helper accepts (ADDR_WIDTH up to 8).
  localparam int MAX_DEPTH      = 256;

  // Low bit of port 'port' inside a packed multi-port bus of 'width'-bit lanes.
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

  // Number of set bits; callers zero-extend narrower busy vectors.
  function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_read_port.sv
// One combinational read port: zero-register masking, write-back bypass
// and busy masking applied on top of the raw array value.
module regfile_read_port
  import regfile_scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  busy_bit,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_busy
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic is_zero;
  logic wr_hit;

  // Select array data, forwarded write data or hardwired zero for this port.
  always_comb begin
    is_zero = ZR && (raddr == '0);
    wr_hit  = BP && wen && (waddr == raddr);
    rdata   = rf_data;
    rd_busy = busy_bit;
    if (is_zero) begin
      rdata   = '0;
      rd_busy = 1'b0;
    end else if (wr_hit) begin
      rdata   = wdata;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard for the single-issue core.
// Decode allocates destinations, write-back writes data and clears busy.
//
// Allocation handshake: alloc_valid/alloc_addr are offered by decode; the
// request is taken on a posedge where alloc_valid && alloc_ready. alloc_ready
// is combinational and may depend on alloc_valid, alloc_addr, wen, waddr and
// flush; decode must hold its request (or retry) while alloc_ready is low.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NR_READ    = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NR_READ*ADDR_WIDTH-1:0]    raddr,
  output logic [NR_READ*DATA_WIDTH-1:0]    rdata,
  output logic [NR_READ-1:0]               rd_busy,
  input  logic                             wen,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic                             alloc_valid,
  input  logic [ADDR_WIDTH-1:0]            alloc_addr,
  output logic                             alloc_ready,
  input  logic                             flush,
  output logic [ADDR_WIDTH:0]              busy_cnt,
  output logic                             err_wb_unalloc
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic [DATA_WIDTH-1:0] rf_d [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [CNT_W-1:0]      busy_cnt_q, busy_cnt_d;
  logic                  err_q, err_d;

  logic                  wr_zero;
  logic                  alloc_zero;
  logic                  wr_eff;
  logic [MAX_DEPTH-1:0]  busy_ext;

  // Read ports: each sees the raw array word and busy bit at its address.
  for (genvar i = 0; i < NR_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    assign a = raddr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];

    regfile_read_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_port (
      .raddr    (a),
      .rf_data  (rf_q[a]),
      .busy_bit (busy_q[a]),
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata    (rdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
      .rd_busy  (rd_busy[i])
    );
  end

  // Accept an allocation when the target is free or is being freed this cycle.
  always_comb begin
    alloc_ready = alloc_valid && !flush &&
                  (!busy_q[alloc_addr] || (wen && (waddr == alloc_addr)));
  end

  // Next array, busy vector, count and error flag; later rules override earlier.
  always_comb begin
    wr_zero    = ZR && (waddr == '0);
    alloc_zero = ZR && (alloc_addr == '0);
    wr_eff     = wen && !wr_zero;
    rf_d       = rf_q;
    busy_d     = busy_q;
    err_d      = err_q;
    if (wr_eff) begin
      rf_d[waddr]   = wdata;
      busy_d[waddr] = 1'b0;
      if (!busy_q[waddr] && !flush) begin
        err_d = 1'b1;
      end
    end
    if (alloc_ready && !alloc_zero) begin
      busy_d[alloc_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        rf_d[r] = '0;
      end
      busy_d = '0;
      err_d  = 1'b0;
    end
    busy_ext              = '0;
    busy_ext[DEPTH-1:0]   = busy_d;
    busy_cnt_d            = CNT_W'(popcount(busy_ext));
  end

  // State registers; reset is folded into the next-state logic above.
  always_ff @(posedge clk) begin
    rf_q       <= rf_d;
    busy_q     <= busy_d;
    busy_cnt_q <= busy_cnt_d;
    err_q      <= err_d;
  end

  assign busy_cnt       = busy_cnt_q;
  assign err_wb_unalloc = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed sequences with literal expectations,
// plus a per-cycle comparison against a behavioural register/busy model.
module tb_regfile_scoreboard;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NREG = 32;

  logic           clk;
  logic           rst;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]  rd_busy;
  logic           wen;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  wdata;
  logic           alloc_valid;
  logic [AW-1:0]  alloc_addr;
  logic           alloc_ready;
  logic           flush;
  logic [AW:0]    busy_cnt;
  logic           err_wb_unalloc;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NR_READ    (NR),
    .ZERO_REG   (1),
    .BYPASS     (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .raddr          (raddr),
    .rdata          (rdata),
    .rd_busy        (rd_busy),
    .wen            (wen),
    .waddr          (waddr),
    .wdata          (wdata),
    .alloc_valid    (alloc_valid),
    .alloc_addr     (alloc_addr),
    .alloc_ready    (alloc_ready),
    .flush          (flush),
    .busy_cnt       (busy_cnt),
    .err_wb_unalloc (err_wb_unalloc)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain register contents, set of busy registers, sticky error.
  logic [DW-1:0] m_rf [NREG];
  bit            m_busy [NREG];
  bit            m_err;
  bit            m_valid = 1'b0;

  function automatic logic [DW-1:0] exp_rdata(input int a);
    if (a == 0) return '0;
    if (wen && waddr == a) return wdata;
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
    if (wen && waddr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_ready();
    if (!alloc_valid || flush) return 1'b0;
    if (alloc_addr == 0) return 1'b1;
    if (!m_busy[alloc_addr]) return 1'b1;
    return wen && (waddr == alloc_addr);
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int r = 0; r < NREG; r++) if (m_busy[r]) n++;
    return n;
  endfunction

  // Compare on the falling edge, then advance the model as the next posedge will.
  always @(negedge clk) begin
    logic acc;
    if (m_valid) begin
      for (int p = 0; p < NR; p++) begin
        int a;
        a = int'(raddr[p*AW +: AW]);
        chk($sformatf("model_rdata%0d", p), rdata[p*DW +: DW], exp_rdata(a));
        chk($sformatf("model_rd_busy%0d", p), 32'(rd_busy[p]), 32'(exp_busy(a)));
      end
      chk("model_alloc_ready", 32'(alloc_ready), 32'(exp_ready()));
      chk("model_busy_cnt", 32'(busy_cnt), 32'(busy_count()));
      chk("model_err", 32'(err_wb_unalloc), 32'(m_err));
    end
    acc = exp_ready();
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_rf[r]   = '0;
        m_busy[r] = 1'b0;
      end
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else begin
      if (wen && waddr != 0) begin
        if (!m_busy[waddr] && !flush) m_err = 1'b1;
        m_rf[waddr]   = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (acc && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
      if (flush) for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen         = 1'b0;
    waddr       = '0;
    wdata       = '0;
    alloc_valid = 1'b0;
    alloc_addr  = '0;
    flush       = 1'b0;
  endtask

  task automatic set_rd(input int p0, input int p1);
    raddr[0*AW +: AW] = AW'(p0);
    raddr[1*AW +: AW] = AW'(p1);
  endtask

  task automatic do_wr(input int a, input logic [DW-1:0] d);
    wen = 1'b1; waddr = AW'(a); wdata = d;
  endtask

  task automatic do_alloc(input int a);
    alloc_valid = 1'b1; alloc_addr = AW'(a);
  endtask

  initial begin
    rst = 1'b1;
    raddr = '0;
    idle();
    step();
    step();
    rst = 1'b0;

    // 1: reset state
    set_rd(5, 0);
    @(negedge clk);
    chk("t1_rdata0", rdata[31:0], 32'h0);
    chk("t1_rdata1", rdata[63:32], 32'h0);
    chk("t1_rd_busy", 32'(rd_busy), 32'h0);
    chk("t1_busy_cnt", 32'(busy_cnt), 32'd0);
    chk("t1_err", 32'(err_wb_unalloc), 32'd0);
    step();

    // 2: alloc x5, then write-back with bypass
    do_alloc(5);
    @(negedge clk);
    chk("t2_alloc_ready", 32'(alloc_ready), 32'd1);
    step();
    idle();
    do_wr(5, 32'hDEADBEEF);
    @(negedge clk);
    chk("t2_bypass_rdata0", rdata[31:0], 32'hDEADBEEF);
    chk("t2_bypass_busy0", 32'(rd_busy[0]), 32'd0);
    chk("t2_busy_cnt_pre", 32'(busy_cnt), 32'd1);
    step();
    idle();
    @(negedge clk);
    chk("t2_busy_cnt_post", 32'(busy_cnt), 32'd0);
    chk("t2_rdata0_after", rdata[31:0], 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("t2_rdata0_held", rdata[31:0], 32'hDEADBEEF);
    step();

    // 3: double alloc of x7
    do_alloc(7);
    @(negedge clk);
    chk("t3_first_ready", 32'(alloc_ready), 32'd1);
    step();
    @(negedge clk);
    chk("t3_second_ready", 32'(alloc_ready), 32'd0);
    chk("t3_busy_cnt", 32'(busy_cnt), 32'd1);
    step();
    idle();
    set_rd(7, 7);
    @(negedge clk);
    chk("t3_busy_cnt_hold", 32'(busy_cnt), 32'd1);
    chk("t3_rd_busy_both", 32'(rd_busy), 32'h3);
    step();

    // 4: alloc and write x7 in the same cycle while busy
    do_alloc(7);
    do_wr(7, 32'h1234);
    @(negedge clk);
    chk("t4_alloc_ready", 32'(alloc_ready), 32'd1);
    step();
    idle();
    @(negedge clk);
    chk("t4_rd_busy0", 32'(rd_busy[0]), 32'd1);
    chk("t4_rdata0", rdata[31:0], 32'h1234);
    chk("t4_rdata1", rdata[63:32], 32'h1234);
    chk("t4_busy_cnt", 32'(busy_cnt), 32'd1);
    step();

    // 5: zero register and unallocated write-back
    set_rd(0, 7);
    do_wr(0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("t5_x0_no_bypass", rdata[31:0], 32'h0);
    step();
    idle();
    do_alloc(0);
    @(negedge clk);
    chk("t5_x0_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("t5_x0_rdata", rdata[31:0], 32'h0);
    step();
    idle();
    @(negedge clk);
    chk("t5_x0_not_busy", 32'(rd_busy[0]), 32'd0);
    chk("t5_busy_cnt", 32'(busy_cnt), 32'd1);
    chk("t5_err_clear", 32'(err_wb_unalloc), 32'd0);
    step();
    do_wr(9, 32'h99);
    step();
    idle();
    @(negedge clk);
    chk("t5_err_set", 32'(err_wb_unalloc), 32'd1);
    step();
    step();
    @(negedge clk);
    chk("t5_err_sticky", 32'(err_wb_unalloc), 32'd1);

    // 6: flush with a competing alloc, then reset mid-sequence
    step();
    do_wr(7, 32'h77); step();
    do_wr(1, 32'h11); step();
    do_wr(2, 32'h22); step();
    do_wr(3, 32'h33); step();
    idle();
    do_alloc(1); step();
    do_alloc(2); step();
    do_alloc(3); step();
    idle();
    @(negedge clk);
    chk("t6_busy_cnt3", 32'(busy_cnt), 32'd3);
    step();
    flush = 1'b1;
    do_alloc(4);
    @(negedge clk);
    chk("t6_flush_ready", 32'(alloc_ready), 32'd0);
    step();
    idle();
    set_rd(1, 3);
    @(negedge clk);
    chk("t6_busy_cnt0", 32'(busy_cnt), 32'd0);
    chk("t6_rdata_x1", rdata[31:0], 32'h11);
    chk("t6_rdata_x3", rdata[63:32], 32'h33);
    chk("t6_rd_busy", 32'(rd_busy), 32'h0);
    step();
    do_alloc(2); step();
    do_alloc(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    set_rd(1, 2);
    @(negedge clk);
    chk("t6_rst_rdata0", rdata[31:0], 32'h0);
    chk("t6_rst_rdata1", rdata[63:32], 32'h0);
    chk("t6_rst_busy_cnt", 32'(busy_cnt), 32'd0);
    chk("t6_rst_err", 32'(err_wb_unalloc), 32'd0);
    step();
    step();

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
